// File: rtl/game_state_ctrl.sv
// rtl/game_state_ctrl.sv - game flow, score, level and charged-shot control for the display interface
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   vsync        VGA vsync; a falling edge is one frame tick
//   btn_start    start/continue button (already synchronised)
//   btn_fire     fire button (already synchronised)
//   hit_ship     1-cycle pulse, player shot hit a ship
//   player_hit   1-cycle pulse, player destroyed
//   mode         000 title, 001 game, 010 in-between, 011 win, 100 game over
//   level        current level, 1..MAX_LEVEL
//   score        3-digit BCD {hundreds, tens, ones}
//   charge_count shot charge, 0..7
//   shot_fire    1-cycle pulse, charged shot released

module game_state_ctrl #(
    parameter int unsigned MAX_LEVEL       = 5,
    parameter int unsigned KILLS_PER_LEVEL = 8,
    parameter int unsigned POINTS          = 5,
    parameter int unsigned CHARGE_FRAMES   = 30,
    parameter int unsigned INBET_FRAMES    = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync,
    input  logic        btn_start,
    input  logic        btn_fire,
    input  logic        hit_ship,
    input  logic        player_hit,
    output logic [2:0]  mode,
    output logic [2:0]  level,
    output logic [11:0] score,
    output logic [2:0]  charge_count,
    output logic        shot_fire
);

    typedef enum logic [2:0] {
        S_TITLE = 3'b000,
        S_GAME  = 3'b001,
        S_INBET = 3'b010,
        S_WIN   = 3'b011,
        S_GOVER = 3'b100
    } state_e;

    localparam logic [2:0] LEVEL_LAST   = 3'(MAX_LEVEL);
    localparam logic [7:0] KILLS_TARGET = 8'(KILLS_PER_LEVEL);
    localparam logic [4:0] POINTS_W     = 5'(POINTS);
    localparam logic [7:0] CHARGE_LAST  = 8'(CHARGE_FRAMES - 1);
    localparam logic [7:0] INBET_LAST   = 8'(INBET_FRAMES - 1);

    state_e      mode_q, mode_d;
    logic [2:0]  level_q, level_d;
    logic [11:0] score_q, score_d;
    logic [2:0]  charge_q, charge_d;
    logic        shot_fire_q, shot_fire_d;
    logic [7:0]  kills_q, kills_d;
    logic [7:0]  charge_frm_q, charge_frm_d;
    logic [7:0]  inbet_frm_q, inbet_frm_d;
    logic        prev_vsync_q, prev_vsync_d;
    logic        prev_start_q, prev_start_d;
    logic        prev_fire_q, prev_fire_d;

    logic frame_tick, start_edge, fire_edge;

    assign frame_tick = prev_vsync_q & ~vsync;
    assign start_edge = btn_start & ~prev_start_q;
    assign fire_edge  = btn_fire & ~prev_fire_q;

    // BCD add with per-digit carry; a carry out of the hundreds digit
    // means the sum passed 999, so the result pins at 999.
    logic [4:0]  ones_sum, ones_adj, tens_sum, tens_adj, hund_sum, hund_adj;
    logic        ones_carry, tens_carry, hund_carry;
    logic [11:0] score_add;
    logic [7:0]  kills_inc;

    always_comb begin
        ones_sum   = {1'b0, score_q[3:0]} + POINTS_W;
        ones_adj   = ones_sum - 5'd10;
        ones_carry = (ones_sum > 5'd9);
        tens_sum   = {1'b0, score_q[7:4]} + {4'd0, ones_carry};
        tens_adj   = tens_sum - 5'd10;
        tens_carry = (tens_sum > 5'd9);
        hund_sum   = {1'b0, score_q[11:8]} + {4'd0, tens_carry};
        hund_adj   = hund_sum - 5'd10;
        hund_carry = (hund_sum > 5'd9);
        if (hund_carry) begin
            score_add = 12'h999;
        end else begin
            score_add = {hund_sum[3:0],
                         tens_carry ? tens_adj[3:0] : tens_sum[3:0],
                         ones_carry ? ones_adj[3:0] : ones_sum[3:0]};
        end
        // hund_adj is never needed: a hundreds carry saturates instead.
        kills_inc = kills_q + 8'd1;
    end

    always_comb begin
        mode_d       = mode_q;
        level_d      = level_q;
        score_d      = score_q;
        charge_d     = charge_q;
        shot_fire_d  = 1'b0;
        kills_d      = kills_q;
        charge_frm_d = charge_frm_q;
        inbet_frm_d  = inbet_frm_q;
        prev_vsync_d = vsync;
        prev_start_d = btn_start;
        prev_fire_d  = btn_fire;

        case (mode_q)
            S_TITLE: begin
                if (start_edge) begin
                    mode_d       = S_GAME;
                    level_d      = 3'd1;
                    score_d      = '0;
                    charge_d     = '0;
                    kills_d      = '0;
                    charge_frm_d = '0;
                end
            end
            S_GAME: begin
                if (frame_tick) begin
                    // A full charge parks the frame counter at zero.
                    if (charge_q == 3'd7) begin
                        charge_frm_d = '0;
                    end else if (charge_frm_q == CHARGE_LAST) begin
                        charge_d     = charge_q + 3'd1;
                        charge_frm_d = '0;
                    end else begin
                        charge_frm_d = charge_frm_q + 8'd1;
                    end
                end
                if (fire_edge && (charge_q == 3'd7)) begin
                    shot_fire_d = 1'b1;
                    charge_d    = '0;
                end
                // Losing the player masks a ship hit in the same cycle.
                if (player_hit) begin
                    mode_d = S_GOVER;
                end else if (hit_ship) begin
                    score_d = score_add;
                    kills_d = kills_inc;
                    if (kills_inc == KILLS_TARGET) begin
                        mode_d      = (level_q == LEVEL_LAST) ? S_WIN : S_INBET;
                        inbet_frm_d = '0;
                    end
                end
            end
            S_INBET: begin
                if (start_edge || (frame_tick && (inbet_frm_q == INBET_LAST))) begin
                    mode_d       = S_GAME;
                    level_d      = level_q + 3'd1;
                    kills_d      = '0;
                    charge_d     = '0;
                    charge_frm_d = '0;
                    inbet_frm_d  = '0;
                end else if (frame_tick) begin
                    inbet_frm_d = inbet_frm_q + 8'd1;
                end
            end
            S_WIN, S_GOVER: begin
                if (start_edge) begin
                    mode_d = S_TITLE;
                end
            end
            default: begin
                mode_d = S_TITLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q       <= S_TITLE;
            level_q      <= 3'd1;
            score_q      <= '0;
            charge_q     <= '0;
            shot_fire_q  <= 1'b0;
            kills_q      <= '0;
            charge_frm_q <= '0;
            inbet_frm_q  <= '0;
            prev_vsync_q <= 1'b0;
            prev_start_q <= 1'b0;
            prev_fire_q  <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            level_q      <= level_d;
            score_q      <= score_d;
            charge_q     <= charge_d;
            shot_fire_q  <= shot_fire_d;
            kills_q      <= kills_d;
            charge_frm_q <= charge_frm_d;
            inbet_frm_q  <= inbet_frm_d;
            prev_vsync_q <= prev_vsync_d;
            prev_start_q <= prev_start_d;
            prev_fire_q  <= prev_fire_d;
        end
    end

    assign mode         = mode_q;
    assign level        = level_q;
    assign score        = score_q;
    assign charge_count = charge_q;
    assign shot_fire    = shot_fire_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// tb/tb_game_state_ctrl.sv - self-checking bench for game_state_ctrl

module tb_game_state_ctrl;

    localparam int T_TITLE = 0;
    localparam int T_GAME  = 1;
    localparam int T_INBET = 2;
    localparam int T_WIN   = 3;
    localparam int T_GOVER = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vsync = 1'b0;
    logic btn_start = 1'b0;
    logic btn_fire = 1'b0;
    logic hit_ship = 1'b0;
    logic player_hit = 1'b0;

    logic [2:0]  mode_a, level_a, charge_a, mode_b, level_b, charge_b;
    logic [11:0] score_a, score_b;
    logic        shot_a, shot_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    game_state_ctrl #(
        .MAX_LEVEL(2), .KILLS_PER_LEVEL(2), .POINTS(5), .CHARGE_FRAMES(2), .INBET_FRAMES(4)
    ) dut_a (
        .clk(clk), .rst(rst), .vsync(vsync), .btn_start(btn_start), .btn_fire(btn_fire),
        .hit_ship(hit_ship), .player_hit(player_hit), .mode(mode_a), .level(level_a),
        .score(score_a), .charge_count(charge_a), .shot_fire(shot_a)
    );

    game_state_ctrl #(
        .MAX_LEVEL(7), .KILLS_PER_LEVEL(255), .POINTS(5), .CHARGE_FRAMES(3), .INBET_FRAMES(6)
    ) dut_b (
        .clk(clk), .rst(rst), .vsync(vsync), .btn_start(btn_start), .btn_fire(btn_fire),
        .hit_ship(hit_ship), .player_hit(player_hit), .mode(mode_b), .level(level_b),
        .score(score_b), .charge_count(charge_b), .shot_fire(shot_b)
    );

    // Reference model state: plain integers, score held in binary.
    typedef struct {
        int mode;
        int level;
        int score;
        int charge;
        int shot;
        int kills;
        int cfrm;
        int ifrm;
        int pv;
        int ps;
        int pf;
    } mst_t;

    mst_t ma, mb;

    function automatic mst_t step(input mst_t s, input int r, input int v, input int bs,
                                  input int bf, input int hs, input int ph, input int maxl,
                                  input int kpl, input int pts, input int cf, input int inf);
        mst_t n;
        int ft, se, fe;
        n = s;
        ft = (s.pv == 1 && v == 0) ? 1 : 0;
        se = (bs == 1 && s.ps == 0) ? 1 : 0;
        fe = (bf == 1 && s.pf == 0) ? 1 : 0;
        n.pv = v;
        n.ps = bs;
        n.pf = bf;
        n.shot = 0;
        if (r != 0) begin
            n = '{default: 0};
            n.level = 1;
            return n;
        end
        if (s.mode == T_TITLE) begin
            if (se != 0) begin
                n.mode = T_GAME;
                n.level = 1;
                n.score = 0;
                n.charge = 0;
                n.kills = 0;
                n.cfrm = 0;
            end
        end else if (s.mode == T_GAME) begin
            if (ft != 0) begin
                if (s.charge == 7) n.cfrm = 0;
                else if (s.cfrm + 1 == cf) begin
                    n.charge = s.charge + 1;
                    n.cfrm = 0;
                end else n.cfrm = s.cfrm + 1;
            end
            if (fe != 0 && s.charge == 7) begin
                n.shot = 1;
                n.charge = 0;
            end
            if (ph != 0) n.mode = T_GOVER;
            else if (hs != 0) begin
                n.score = (s.score + pts > 999) ? 999 : s.score + pts;
                n.kills = s.kills + 1;
                if (n.kills == kpl) begin
                    n.mode = (s.level == maxl) ? T_WIN : T_INBET;
                    n.ifrm = 0;
                end
            end
        end else if (s.mode == T_INBET) begin
            if (se != 0 || (ft != 0 && s.ifrm + 1 == inf)) begin
                n.mode = T_GAME;
                n.level = s.level + 1;
                n.kills = 0;
                n.charge = 0;
                n.cfrm = 0;
                n.ifrm = 0;
            end else if (ft != 0) n.ifrm = s.ifrm + 1;
        end else begin
            if (se != 0) n.mode = T_TITLE;
        end
        return n;
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_dut(input string tag, input logic [2:0] m, input logic [2:0] l,
                             input logic [11:0] s, input logic [2:0] c, input logic f,
                             input mst_t e);
        chk({tag, "_mode"}, 12'(m), 12'(e.mode));
        chk({tag, "_level"}, 12'(l), 12'(e.level));
        chk({tag, "_score"}, s, to_bcd(e.score));
        chk({tag, "_charge"}, 12'(c), 12'(e.charge));
        chk({tag, "_shot"}, 12'(f), 12'(e.shot));
    endtask

    // Apply one cycle of inputs, advance both models, then compare 1 ns after the edge.
    task automatic tick(input int r, input int v, input int bs, input int bf,
                        input int hs, input int ph);
        rst = 1'(r);
        vsync = 1'(v);
        btn_start = 1'(bs);
        btn_fire = 1'(bf);
        hit_ship = 1'(hs);
        player_hit = 1'(ph);
        @(posedge clk);
        ma = step(ma, r, v, bs, bf, hs, ph, 2, 2, 5, 2, 4);
        mb = step(mb, r, v, bs, bf, hs, ph, 7, 255, 5, 3, 6);
        #1;
        check_dut("a", mode_a, level_a, score_a, charge_a, shot_a, ma);
        check_dut("b", mode_b, level_b, score_b, charge_b, shot_b, mb);
    endtask

    task automatic frame();
        tick(0, 1, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int rv, rbs, rbf;
        ma = '{default: 0};
        mb = '{default: 0};

        // Reset and start
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        chk("rst_mode", 12'(mode_a), 12'h000);
        chk("rst_level", 12'(level_a), 12'h001);
        chk("rst_score", score_a, 12'h000);
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0);
        chk("start_mode", 12'(mode_a), 12'h001);
        tick(0, 0, 0, 0, 0, 0);

        // Charge to saturation, then fire twice
        repeat (18) frame();
        chk("charge_sat", 12'(charge_a), 12'h007);
        tick(0, 0, 0, 1, 0, 0);
        chk("fire_pulse", 12'(shot_a), 12'h001);
        chk("fire_clear", 12'(charge_a), 12'h000);
        tick(0, 0, 0, 0, 0, 0);
        chk("fire_single", 12'(shot_a), 12'h000);
        tick(0, 0, 0, 1, 0, 0);
        chk("fire_empty", 12'(shot_a), 12'h000);
        tick(0, 0, 0, 0, 0, 0);

        // Score and level flow
        repeat (3) begin
            tick(0, 0, 0, 0, 1, 0);
            tick(0, 0, 0, 0, 0, 0);
        end
        chk("inbet_mode", 12'(mode_a), 12'h002);
        chk("score_b_15", score_b, 12'h015);
        repeat (4) frame();
        chk("lvl2_mode", 12'(mode_a), 12'h001);
        chk("lvl2_level", 12'(level_a), 12'h002);
        repeat (2) begin
            tick(0, 0, 0, 0, 1, 0);
            tick(0, 0, 0, 0, 0, 0);
        end
        chk("win_mode", 12'(mode_a), 12'h003);
        chk("win_score", score_a, 12'h020);
        repeat (200) tick(0, 0, 0, 0, 1, 0);
        chk("score_sat", score_b, 12'h999);

        // Back to title, new game, then simultaneous hit and loss
        tick(0, 0, 1, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 1);
        chk("gover_mode", 12'(mode_b), 12'h004);
        chk("gover_score", score_b, 12'h999);
        tick(0, 0, 1, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        chk("gover_title", 12'(mode_b), 12'h000);

        // Mid-game reset with score 015 and charge 4 on instance b
        tick(0, 0, 1, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        repeat (12) frame();
        repeat (3) begin
            tick(0, 0, 0, 0, 1, 0);
            tick(0, 0, 0, 0, 0, 0);
        end
        chk("pre_rst_score", score_b, 12'h015);
        chk("pre_rst_charge", 12'(charge_b), 12'h004);
        tick(1, 0, 0, 1, 1, 0);
        chk("mid_rst_mode", 12'(mode_b), 12'h000);
        chk("mid_rst_score", score_b, 12'h000);
        chk("mid_rst_shot", 12'(shot_b), 12'h000);
        tick(0, 0, 0, 0, 0, 0);

        // Randomised traffic
        rv = 0;
        rbs = 0;
        rbf = 0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 1) == 0) rv = 1 - rv;
            if ($urandom_range(0, 5) == 0) rbs = 1 - rbs;
            if ($urandom_range(0, 2) == 0) rbf = 1 - rbf;
            tick(($urandom_range(0, 299) == 0) ? 1 : 0, rv, rbs, rbf,
                 ($urandom_range(0, 4) == 0) ? 1 : 0,
                 ($urandom_range(0, 59) == 0) ? 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
